// File: rtl/mac_pkg.sv
// Shared defaults and state encoding for the pipelined MAC unit.
package mac_pkg;

  localparam int DEF_INPUT_LENGTH = 16;
  localparam int DEF_ACC_LENGTH   = 40;

  // ACCUM: taking operand pairs; DONE: holding a finished dot product.
  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } mac_state_e;

endpackage

// File: rtl/fast_unsigned_multiplier.sv
// Combinational unsigned multiplier sitting between the S1 and S2 registers.
module fast_unsigned_multiplier #(
  parameter int INPUT_LENGTH  = 16,
  parameter int OUTPUT_LENGTH = 32
) (
  input  logic [INPUT_LENGTH-1:0]  a_i,
  input  logic [INPUT_LENGTH-1:0]  b_i,
  output logic [OUTPUT_LENGTH-1:0] product_o
);

  // Widen both operands first so the product is computed at full width.
  assign product_o = OUTPUT_LENGTH'(a_i) * OUTPUT_LENGTH'(b_i);

endmodule

// File: rtl/pipelined_mac_unit.sv
// Three-stage unsigned multiply-accumulate computing one dot product per
// vector: S1 operand register, S2 product register, S3 accumulator.
// The finished sum is held in DONE until the consumer takes it.
module pipelined_mac_unit
  import mac_pkg::*;
#(
  parameter int INPUT_LENGTH = DEF_INPUT_LENGTH,
  parameter int ACC_LENGTH   = DEF_ACC_LENGTH
) (
  input  logic                    iClk,
  input  logic                    iRstN,
  input  logic [INPUT_LENGTH-1:0] iA,
  input  logic [INPUT_LENGTH-1:0] iB,
  input  logic                    iValid,
  input  logic                    iLast,
  output logic                    oReady,
  output logic                    oValid,
  input  logic                    iReady,
  output logic [ACC_LENGTH-1:0]   oAcc,
  output logic                    oOverflow
);

  localparam int PROD_W = 2 * INPUT_LENGTH;
  localparam int SUM_W  = ACC_LENGTH + 1;

  // Pipeline registers
  logic                    s1_valid_q, s1_last_q;
  logic [INPUT_LENGTH-1:0] s1_a_q, s1_b_q;
  logic                    s2_valid_q, s2_last_q;
  logic [PROD_W-1:0]       s2_prod_q;
  logic [PROD_W-1:0]       product;

  // Accumulator and control
  mac_state_e              state_q, state_d;
  logic [ACC_LENGTH-1:0]   acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic [SUM_W-1:0]        sum;
  logic                    accept;

  // Once a last-tagged pair is in flight, hold off the next vector so its
  // pairs cannot be summed into the current result.
  assign oReady = (state_q == ACCUM)
                  && !(s1_valid_q && s1_last_q)
                  && !(s2_valid_q && s2_last_q);
  assign accept = iValid && oReady;

  fast_unsigned_multiplier #(
    .INPUT_LENGTH (INPUT_LENGTH),
    .OUTPUT_LENGTH(PROD_W)
  ) u_mult (
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .product_o(product)
  );

  // The extra top bit of the sum is the carry out of the accumulator.
  assign sum = SUM_W'(acc_q) + SUM_W'(s2_prod_q);

  // S1/S2 pipeline: items advance every cycle, there is no stall path.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_prod_q  <= '0;
    end else begin
      s1_valid_q <= accept;
      s1_last_q  <= accept && iLast;
      s1_a_q     <= iA;
      s1_b_q     <= iB;
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_valid_q && s1_last_q;
      s2_prod_q  <= product;
    end
  end

  // Next-state logic: accumulate in ACCUM, release and clear in DONE.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ACCUM: begin
        if (s2_valid_q) begin
          acc_d = sum[ACC_LENGTH-1:0];
          ovf_d = ovf_q | sum[ACC_LENGTH];
          if (s2_last_q) state_d = DONE;
        end
      end
      DONE: begin
        if (iReady) begin
          state_d = ACCUM;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State, accumulator and sticky overflow registers.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  // Result is only presented while valid; otherwise outputs read as zero.
  assign oValid    = (state_q == DONE);
  assign oAcc      = oValid ? acc_q : '0;
  assign oOverflow = oValid && ovf_q;

endmodule
